video_line_scanner: RTL and testbench

VIDEO_LINE_SCANNER -- requirements
Module: video_line_scanner

---
 rtl/video_pkg.sv | 32 +++
 rtl/video_timing_gen.sv | 59 +++++
 rtl/video_line_scanner.sv | 153 +++++++++++++++
 tb/tb_video_line_scanner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared composite-video timing constants and PWM modulation thresholds.
// Modulation is negative, so sync sits at the highest threshold and white at the lowest.
package video_pkg;

  localparam int VID_LINE_CYCLES       = 1728;
  localparam int VID_SYNC_CYCLES       = 127;
  localparam int VID_ACTIVE_START      = 281;
  localparam int VID_PIXEL_DIV         = 4;
  localparam int VID_LINE_PIXELS       = 300;
  localparam int VID_FIELD_LINES       = 312;
  localparam int VID_ACTIVE_LINE_START = 8;
  localparam int VID_ACTIVE_LINES      = 304;
  localparam int VID_VSYNC_LINES       = 3;
  localparam int VID_ADDR_W            = 10;

  localparam logic [7:0] VID_THR_SYNC  = 8'd12;
  localparam logic [7:0] VID_THR_BLACK = 8'd9;
  localparam logic [7:0] VID_THR_WHITE = 8'd3;

  typedef enum logic [1:0] {
    REG_VSYNC,
    REG_EQUALIZE,
    REG_ACTIVE
  } line_region_t;

  function automatic logic [7:0] pixel_level(input logic       lit,
                                             input logic [7:0] thr_white,
                                             input logic [7:0] thr_black);
    return lit ? thr_white : thr_black;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical scan counters with field toggle and per-line region classification.
// All counters collapse to the scan origin whenever enable is low.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int LINE_CYCLES       = VID_LINE_CYCLES,
  parameter int FIELD_LINES       = VID_FIELD_LINES,
  parameter int ACTIVE_LINE_START = VID_ACTIVE_LINE_START,
  parameter int ACTIVE_LINES      = VID_ACTIVE_LINES,
  parameter int H_W               = $clog2(LINE_CYCLES),
  parameter int L_W               = $clog2(FIELD_LINES)
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  output logic [H_W-1:0] h,
  output logic [L_W-1:0] line,
  output logic           field,
  output line_region_t   region
);

  localparam logic [H_W-1:0] H_MAX       = H_W'(LINE_CYCLES - 1);
  localparam logic [L_W-1:0] L_MAX       = L_W'(FIELD_LINES - 1);
  localparam logic [L_W-1:0] L_EQ_FIRST  = L_W'(VID_VSYNC_LINES);
  localparam logic [L_W-1:0] L_ACT_FIRST = L_W'(ACTIVE_LINE_START);
  localparam logic [L_W-1:0] L_ACT_LAST  = L_W'(ACTIVE_LINE_START + ACTIVE_LINES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h     <= '0;
      line  <= '0;
      field <= 1'b0;
    end else if (!enable) begin
      h     <= '0;
      line  <= '0;
      field <= 1'b0;
    end else if (h == H_MAX) begin
      h <= '0;
      if (line == L_MAX) begin
        line  <= '0;
        field <= ~field;
      end else begin
        line <= line + 1'b1;
      end
    end else begin
      h <= h + 1'b1;
    end
  end

  // Lines outside vsync and the picture area are treated as equalising lines.
  always_comb begin
    region = REG_EQUALIZE;
    if (line < L_EQ_FIRST)
      region = REG_VSYNC;
    else if ((line >= L_ACT_FIRST) && (line <= L_ACT_LAST))
      region = REG_ACTIVE;
  end

endmodule

// File: rtl/video_line_scanner.sv
// Scans one video line per LINE_CYCLES clocks, fetching each picture line from the line BRAM
// into a local latch and emitting a registered PWM threshold per clock.
module video_line_scanner
  import video_pkg::*;
#(
  parameter int         LINE_CYCLES       = VID_LINE_CYCLES,
  parameter int         SYNC_CYCLES       = VID_SYNC_CYCLES,
  parameter int         ACTIVE_START      = VID_ACTIVE_START,
  parameter int         PIXEL_DIV         = VID_PIXEL_DIV,
  parameter int         LINE_PIXELS       = VID_LINE_PIXELS,
  parameter int         FIELD_LINES       = VID_FIELD_LINES,
  parameter int         ACTIVE_LINE_START = VID_ACTIVE_LINE_START,
  parameter int         ACTIVE_LINES      = VID_ACTIVE_LINES,
  parameter logic [7:0] THR_SYNC          = VID_THR_SYNC,
  parameter logic [7:0] THR_BLACK         = VID_THR_BLACK,
  parameter logic [7:0] THR_WHITE         = VID_THR_WHITE
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic [VID_ADDR_W-1:0]  bram_addr_rd,
  input  logic [LINE_PIXELS-1:0] bram_data_rd,
  output logic [7:0]             pwm_threshold,
  output logic                   field,
  output logic                   frame_start
);

  localparam int H_W = $clog2(LINE_CYCLES);
  localparam int L_W = $clog2(FIELD_LINES);
  localparam int P_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int S_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [H_W-1:0] H_SYNC_END  = H_W'(SYNC_CYCLES);
  localparam logic [H_W-1:0] H_BROAD_END = H_W'(LINE_CYCLES - SYNC_CYCLES);
  localparam logic [H_W-1:0] H_PRELOAD   = H_W'(ACTIVE_START - 1);
  localparam logic [H_W-1:0] H_ACT_START = H_W'(ACTIVE_START);
  localparam logic [H_W-1:0] H_ACT_END   = H_W'(ACTIVE_START + LINE_PIXELS * PIXEL_DIV);
  localparam logic [S_W-1:0] SUB_LAST    = S_W'(PIXEL_DIV - 1);
  localparam logic [P_W-1:0] PIX_LAST    = P_W'(LINE_PIXELS - 1);

  logic [1:0]             rst_sync;
  logic                   rst_sync_n;
  logic [H_W-1:0]         h;
  logic [L_W-1:0]         line;
  line_region_t           region;
  logic [LINE_PIXELS-1:0] line_latch;
  logic [P_W-1:0]         pix_idx;
  logic [S_W-1:0]         sub_cnt;
  logic                   in_window;
  logic [VID_ADDR_W-1:0]  line_addr;
  logic [7:0]             level;

  // Assertion is immediate; release is delayed two clocks so every counter leaves reset together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_sync_n = rst_sync[1];

  video_timing_gen #(
    .LINE_CYCLES       (LINE_CYCLES),
    .FIELD_LINES       (FIELD_LINES),
    .ACTIVE_LINE_START (ACTIVE_LINE_START),
    .ACTIVE_LINES      (ACTIVE_LINES),
    .H_W               (H_W),
    .L_W               (L_W)
  ) u_timing (
    .clk    (clk),
    .rst_n  (rst_sync_n),
    .enable (enable),
    .h      (h),
    .line   (line),
    .field  (field),
    .region (region)
  );

  assign in_window = (h >= H_ACT_START) && (h < H_ACT_END);
  assign line_addr = (field ? VID_ADDR_W'(ACTIVE_LINES) : '0)
                   + VID_ADDR_W'(line) - VID_ADDR_W'(ACTIVE_LINE_START);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)
      bram_addr_rd <= '0;
    else if (!enable)
      bram_addr_rd <= '0;
    else if (h == '0)
      bram_addr_rd <= (region == REG_ACTIVE) ? line_addr : '0;
  end

  // Captured once just before the pixels start, so BRAM writes mid-line cannot tear the picture.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)
      line_latch <= '0;
    else if (enable && (region == REG_ACTIVE) && (h == H_PRELOAD))
      line_latch <= bram_data_rd;
  end

  // pix_idx tracks (h - ACTIVE_START) / PIXEL_DIV without a divider.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      pix_idx <= '0;
      sub_cnt <= '0;
    end else if (!enable || (h == H_PRELOAD)) begin
      pix_idx <= '0;
      sub_cnt <= '0;
    end else if (in_window) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (pix_idx != PIX_LAST)
          pix_idx <= pix_idx + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    level = THR_BLACK;
    case (region)
      REG_VSYNC: begin
        if (h < H_BROAD_END)
          level = THR_SYNC;
      end
      REG_ACTIVE: begin
        if (h < H_SYNC_END)
          level = THR_SYNC;
        else if (in_window)
          level = pixel_level(line_latch[pix_idx], THR_WHITE, THR_BLACK);
      end
      default: begin
        if (h < H_SYNC_END)
          level = THR_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      pwm_threshold <= THR_BLACK;
      frame_start   <= 1'b0;
    end else if (!enable) begin
      pwm_threshold <= THR_BLACK;
      frame_start   <= 1'b0;
    end else begin
      pwm_threshold <= level;
      frame_start   <= (h == '0) && (line == '0) && !field;
    end
  end

endmodule

// File: tb/tb_video_line_scanner.sv
// Directed bench for video_line_scanner on a shortened line; a behavioural scan model
// feeds an expectation queue that is drained one clock later against the DUT outputs.
module tb_video_line_scanner;

  localparam int LC  = 96;
  localparam int SC  = 8;
  localparam int AS  = 16;
  localparam int PD  = 4;
  localparam int LP  = 16;
  localparam int FL  = 312;
  localparam int ALS = 8;
  localparam int AL  = 304;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [9:0]    bram_addr_rd;
  logic [LP-1:0] bram_data_rd;
  logic [7:0]    pwm_threshold;
  logic          field;
  logic          frame_start;

  logic [LP-1:0] mem [0:1023];

  typedef struct {
    logic [7:0] pwm;
    logic       fs;
    logic [9:0] addr;
  } exp_t;

  exp_t sb_q[$];

  int n_vectors = 0;
  int n_fail    = 0;
  int fs_count  = 0;

  int            mh     = 0;
  int            ml     = 0;
  int            mf     = 0;
  int            maddr  = 0;
  logic [LP-1:0] mlatch = '0;

  video_line_scanner #(
    .LINE_CYCLES       (LC),
    .SYNC_CYCLES       (SC),
    .ACTIVE_START      (AS),
    .PIXEL_DIV         (PD),
    .LINE_PIXELS       (LP),
    .FIELD_LINES       (FL),
    .ACTIVE_LINE_START (ALS),
    .ACTIVE_LINES      (AL),
    .THR_SYNC          (8'd12),
    .THR_BLACK         (8'd9),
    .THR_WHITE         (8'd3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .bram_addr_rd  (bram_addr_rd),
    .bram_data_rd  (bram_data_rd),
    .pwm_threshold (pwm_threshold),
    .field         (field),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  // Line BRAM: read data valid one clock after the address.
  always @(posedge clk) bram_data_rd <= mem[bram_addr_rd];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vectors++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] modelLevel();
    logic active;
    active = (ml >= ALS) && (ml < ALS + AL);
    if (ml < 3)
      return (mh < LC - SC) ? 8'd12 : 8'd9;
    if (mh < SC)
      return 8'd12;
    if (active && (mh >= AS) && (mh < AS + LP * PD))
      return mlatch[(mh - AS) / PD] ? 8'd3 : 8'd9;
    return 8'd9;
  endfunction

  // One clock: predict from the current scan position, then compare after the edge.
  task automatic applyStimulus();
    exp_t e;
    logic active;
    active = (ml >= ALS) && (ml < ALS + AL);
    e.pwm  = enable ? modelLevel() : 8'd9;
    e.fs   = enable && (mh == 0) && (ml == 0) && (mf == 0);
    if (enable && active && (mh == AS - 1))
      mlatch = mem[maddr];
    if (!enable)
      maddr = 0;
    else if (mh == 0)
      maddr = active ? (mf * AL + ml - ALS) : 0;
    e.addr = 10'(maddr);
    if (!enable) begin
      mh = 0; ml = 0; mf = 0;
    end else if (mh == LC - 1) begin
      mh = 0;
      if (ml == FL - 1) begin
        ml = 0;
        mf = 1 - mf;
      end else begin
        ml++;
      end
    end else begin
      mh++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checkOutput("pwm", 32'(pwm_threshold), 32'(e.pwm));
    checkOutput("frame_start", 32'(frame_start), 32'(e.fs));
    checkOutput("addr", 32'(bram_addr_rd), 32'(e.addr));
    checkOutput("field", 32'(field), 32'(mf));
    if (frame_start === 1'b1)
      fs_count++;
  endtask

  task automatic runUntil(input int f, input int l, input int hh);
    int   budget;
    logic reached;
    budget = 2 * FL * LC + LC;
    while (!((mf == f) && (ml == l) && (mh == hh)) && (budget > 0)) begin
      applyStimulus();
      budget--;
    end
    reached = (mf == f) && (ml == l) && (mh == hh);
    checkOutput("reach_position", 32'(reached), 32'd1);
  endtask

  task automatic expectPwm(input string tag, input logic [7:0] value);
    applyStimulus();
    checkOutput(tag, 32'(pwm_threshold), 32'(value));
  endtask

  initial begin
    $display("[TB] video_line_scanner bench start");
    rst_n  = 1'b0;
    enable = 1'b0;
    mem[0] = 16'h5555;
    mem[1] = 16'hF00F;
    for (int i = 2; i < 1024; i++)
      mem[i] = LP'($urandom);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pwm", 32'(pwm_threshold), 32'd9);
    checkOutput("reset_addr", 32'(bram_addr_rd), 32'd0);
    checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
    checkOutput("reset_field", 32'(field), 32'd0);

    rst_n = 1'b1;
    repeat (4) applyStimulus();
    enable   = 1'b1;
    fs_count = 0;

    runUntil(0, 1, LC - SC - 1);
    expectPwm("vsync_broad_last", 8'd12);
    expectPwm("vsync_after_broad", 8'd9);

    runUntil(0, 5, SC - 1);
    expectPwm("hsync_last", 8'd12);
    expectPwm("hsync_end", 8'd9);

    runUntil(0, 8, AS);
    for (int i = 0; i < 8; i++)
      expectPwm("pixel0_pixel1", (i < 4) ? 8'd3 : 8'd9);
    runUntil(0, 8, AS + 14 * PD);
    expectPwm("pixel14", 8'd3);
    runUntil(0, 8, AS + LP * PD);
    expectPwm("window_end", 8'd9);

    runUntil(0, 9, 40);
    mem[1] = ~mem[1];
    runUntil(0, 9, 60);
    expectPwm("latched_pixel11", 8'd9);
    runUntil(0, 9, 64);
    expectPwm("latched_pixel12", 8'd3);

    runUntil(0, FL - 1, LC - 1);
    checkOutput("field_before_wrap", 32'(field), 32'd0);
    applyStimulus();
    checkOutput("field_after_wrap", 32'(field), 32'd1);

    runUntil(1, 8, 2);
    checkOutput("addr_field1_line8", 32'(bram_addr_rd), 32'd304);

    runUntil(0, 0, 3);
    checkOutput("frame_pulses_two_fields", 32'(fs_count), 32'd2);

    runUntil(0, 9, 41);
    enable = 1'b0;
    applyStimulus();
    checkOutput("drop_pwm", 32'(pwm_threshold), 32'd9);
    checkOutput("drop_addr", 32'(bram_addr_rd), 32'd0);
    repeat (3) applyStimulus();
    enable = 1'b1;
    applyStimulus();
    checkOutput("restart_frame_start", 32'(frame_start), 32'd1);
    checkOutput("restart_pwm", 32'(pwm_threshold), 32'd12);

    runUntil(0, 9, 41);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("async_reset_pwm", 32'(pwm_threshold), 32'd9);
    checkOutput("async_reset_addr", 32'(bram_addr_rd), 32'd0);
    checkOutput("async_reset_frame_start", 32'(frame_start), 32'd0);
    mh = 0; ml = 0; mf = 0; maddr = 0; mlatch = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) applyStimulus();
    enable = 1'b1;
    runUntil(0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

endmodule
